// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and limits for the sequential multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mult_state_t;

    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/nbit_add_sub.sv
// rtl/nbit_add_sub.sv - N-bit adder/subtractor, Sub selects A + ~B + 1
module nbit_add_sub #(
    parameter int N = 9
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Sub,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    logic [N:0] full;

    // Inverting B and injecting Sub as carry-in turns the adder into a subtractor.
    assign full = {1'b0, A} + {1'b0, (B ^ {N{Sub}})} + {{N{1'b0}}, Sub};
    assign Sum  = full[N-1:0];
    assign Cout = full[N];

endmodule

// File: rtl/param_seq_multiplier.sv
// rtl/param_seq_multiplier.sv - shift/add multiplier, one partial product per cycle
module param_seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Signed_Mode,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
    output logic [2*WIDTH-1:0] Product,
    output logic               X,
    output logic               Busy,
    output logic               Done
);

    // One extra bit so count can reach WIDTH, the terminal value that ends CALC.
    localparam int CW = $clog2(WIDTH) + 1;

    mult_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             x_q, x_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    count_q, count_d;

    logic [WIDTH:0]   ext_m;
    logic [WIDTH:0]   add_b;
    logic             sub;
    logic [WIDTH:0]   sum;
    logic             cout;
    logic             x_new;

    // The multiplicand is sign-extended only in signed mode; in signed mode the
    // last multiplier bit carries negative weight, so that step subtracts.
    assign ext_m = {mode_q & m_q[WIDTH-1], m_q};
    assign add_b = b_q[0] ? ext_m : '0;
    assign sub   = mode_q & b_q[0] & (count_q == CW'(WIDTH - 1));
    assign x_new = mode_q ? sum[WIDTH] : cout;

    nbit_add_sub #(
        .N (WIDTH + 1)
    ) u_add_sub (
        .A    ({x_q, a_q}),
        .B    (add_b),
        .Sub  (sub),
        .Sum  (sum),
        .Cout (cout)
    );

    // Next-state and datapath update; registers hold unless a transition or step occurs.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        x_d     = x_q;
        mode_d  = mode_q;
        count_d = count_q;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_CALC;
                    a_d     = '0;
                    x_d     = 1'b0;
                    b_d     = Multiplier;
                    m_d     = Multiplicand;
                    mode_d  = Signed_Mode;
                    count_d = '0;
                end
            end
            ST_CALC: begin
                Busy = 1'b1;
                if (count_q == CW'(WIDTH)) begin
                    state_d = ST_DONE;
                end else begin
                    {x_d, a_d, b_d} = {x_new, sum, b_q[WIDTH-1:1]};
                    count_d         = count_q + CW'(1);
                end
            end
            ST_DONE: begin
                Done = 1'b1;
                if (!Start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over every other update.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            x_q     <= 1'b0;
            mode_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            x_q     <= x_d;
            mode_q  <= mode_d;
            count_q <= count_d;
        end
    end

    assign Product = {a_q, b_q};
    assign X       = x_q;

endmodule

// File: tb/tb_param_seq_multiplier.sv
// tb/tb_param_seq_multiplier.sv - self-checking bench for param_seq_multiplier
module tb_param_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start8, sm8, x8, busy8, done8;
    logic [7:0]  mc8, mp8;
    logic [15:0] prod8;
    logic        start16, sm16, x16, busy16, done16;
    logic [15:0] mc16, mp16;
    logic [31:0] prod16;

    int vectors = 0;
    int miscompares = 0;
    int overlap = 0;

    param_seq_multiplier #(.WIDTH(8)) dut8 (
        .Clk          (clk),
        .Reset        (rst),
        .Start        (start8),
        .Signed_Mode  (sm8),
        .Multiplicand (mc8),
        .Multiplier   (mp8),
        .Product      (prod8),
        .X            (x8),
        .Busy         (busy8),
        .Done         (done8)
    );

    param_seq_multiplier #(.WIDTH(16)) dut16 (
        .Clk          (clk),
        .Reset        (rst),
        .Start        (start16),
        .Signed_Mode  (sm16),
        .Multiplicand (mc16),
        .Multiplier   (mp16),
        .Product      (prod16),
        .X            (x16),
        .Busy         (busy16),
        .Done         (done16)
    );

    typedef struct {
        logic        sm;
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [9];

    always @(negedge clk) begin
        if ((busy8 && done8) || (busy16 && done16)) overlap++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: exact product of the operands interpreted per mode, reduced to 2*w bits.
    function automatic longint model(input int w, input logic sm, input logic [31:0] m, input logic [31:0] q);
        longint a, b, p;
        a = longint'(m);
        b = longint'(q);
        if (sm && m[w-1]) a = a - (longint'(1) << w);
        if (sm && q[w-1]) b = b - (longint'(1) << w);
        p = a * b;
        return p & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Call from just after a negedge while the DUT is IDLE; returns at a negedge in IDLE.
    task automatic run8(input logic sm, input logic [7:0] m, input logic [7:0] q,
                        output logic [15:0] p, output int lat);
        start8 = 1'b1; sm8 = sm; mc8 = m; mp8 = q;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("done8_reached", 32'(done8), 32'd1);
        p = prod8;
        @(negedge clk);
    endtask

    task automatic run16(input logic sm, input logic [15:0] m, input logic [15:0] q,
                         output logic [31:0] p, output int lat);
        start16 = 1'b1; sm16 = sm; mc16 = m; mp16 = q;
        @(posedge clk);
        @(negedge clk);
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("done16_reached", 32'(done16), 32'd1);
        p = prod16;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] p8;
        logic [31:0] p16;
        logic [7:0]  rm, rq;
        logic [15:0] rm16, rq16;
        logic        rs;
        longint      e;
        int          lat, busy_cycles, done_cycles;

        tbl[0] = '{1'b1, 8'h07, 8'hFD, 16'hFFEB};
        tbl[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        tbl[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        tbl[3] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        tbl[4] = '{1'b0, 8'h00, 8'h5A, 16'h0000};
        tbl[5] = '{1'b1, 8'h80, 8'h00, 16'h0000};
        tbl[6] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
        tbl[7] = '{1'b0, 8'h80, 8'h02, 16'h0100};
        tbl[8] = '{1'b1, 8'h80, 8'h7F, 16'hC080};

        rst = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; mc8 = 8'h00; mp8 = 8'h00;
        start16 = 1'b0; sm16 = 1'b0; mc16 = 16'h0000; mp16 = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_prod8", 32'(prod8), 32'h0);
        check("reset_x8", 32'(x8), 32'h0);
        check("reset_busy8", 32'(busy8), 32'h0);
        check("reset_done8", 32'(done8), 32'h0);
        check("reset_prod16", prod16, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run8(tbl[i].sm, tbl[i].m, tbl[i].q, p8, lat);
            check($sformatf("tbl%0d_prod", i), 32'(p8), 32'(tbl[i].exp));
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd9);
        end

        for (int i = 0; i < 150; i++) begin
            rs = 1'($urandom);
            rm = 8'($urandom);
            rq = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rm = 8'h80;
            if ($urandom_range(0, 7) == 0) rq = 8'h00;
            run8(rs, rm, rq, p8, lat);
            e = model(8, rs, 32'(rm), 32'(rq));
            check($sformatf("rand8_%0d_prod", i), 32'(p8), 32'(e[15:0]));
            check($sformatf("rand8_%0d_x", i), 32'(x8), rs ? 32'(e[15]) : 32'd0);
        end

        run16(1'b1, 16'h8000, 16'h0002, p16, lat);
        check("w16_neg_prod", p16, 32'hFFFF0000);
        check("w16_latency", 32'(lat), 32'd17);
        run16(1'b0, 16'hFFFF, 16'hFFFF, p16, lat);
        check("w16_unsigned_max", p16, 32'hFFFE0001);
        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom);
            rm16 = 16'($urandom);
            rq16 = 16'($urandom);
            run16(rs, rm16, rq16, p16, lat);
            e = model(16, rs, 32'(rm16), 32'(rq16));
            check($sformatf("rand16_%0d_prod", i), p16, e[31:0]);
        end

        // Start held high: one pass, Done held until Start drops, Product kept afterwards.
        start8 = 1'b1; sm8 = 1'b1; mc8 = 8'h07; mp8 = 8'hFD;
        busy_cycles = 0;
        done_cycles = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy8) busy_cycles++;
            if (done8) done_cycles++;
        end
        check("hold_busy_cycles", 32'(busy_cycles), 32'd9);
        check("hold_done_cycles", 32'(done_cycles), 32'd21);
        check("hold_prod", 32'(prod8), 32'h0000FFEB);
        start8 = 1'b0;
        @(negedge clk);
        check("hold_idle_done", 32'(done8), 32'd0);
        check("hold_idle_busy", 32'(busy8), 32'd0);
        check("hold_idle_prod", 32'(prod8), 32'h0000FFEB);

        // Reset after four CALC steps, then Start on the first edge after release.
        start8 = 1'b1; sm8 = 1'b0; mc8 = 8'h5A; mp8 = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        check("midreset_busy_before", 32'(busy8), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_busy", 32'(busy8), 32'd0);
        check("midreset_done", 32'(done8), 32'd0);
        check("midreset_prod", 32'(prod8), 32'd0);
        check("midreset_x", 32'(x8), 32'd0);
        rst = 1'b0;
        run8(1'b1, 8'hC3, 8'h25, p8, lat);
        e = model(8, 1'b1, 32'h000000C3, 32'h00000025);
        check("after_reset_prod", 32'(p8), 32'(e[15:0]));
        check("after_reset_latency", 32'(lat), 32'd9);

        // Inputs scrambled throughout CALC must not affect the latched operation.
        start8 = 1'b1; sm8 = 1'b1; mc8 = 8'h9C; mp8 = 8'h35;
        @(posedge clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            start8 = 1'($urandom);
            sm8 = 1'($urandom);
            mc8 = 8'($urandom);
            mp8 = 8'($urandom);
        end
        @(negedge clk);
        start8 = 1'b0;
        e = model(8, 1'b1, 32'h0000009C, 32'h00000035);
        check("scramble_done", 32'(done8), 32'd1);
        check("scramble_prod", 32'(prod8), 32'(e[15:0]));
        @(negedge clk);
        check("scramble_idle_prod", 32'(prod8), 32'(e[15:0]));

        check("busy_done_exclusive", 32'(overlap), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
